pim_unit_arbiter: RTL and testbench

//  Shares one pim_unit between NUM_REQ requesters (e.g. per-tile sub-chunk sequencers) using rotating priority.

---
 rtl/pim_unit_arbiter.sv | 131 +++++++++++++
 tb/tb_pim_unit_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_unit_arbiter.sv
// Rotating-priority arbiter sharing one pim_unit between NUM_REQ requesters.
// Issues a one-cycle trigger, waits for result_valid under a watchdog, and returns a one-hot response.
module pim_unit_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_active_o,
  output logic               pim_valid_o,
  input  logic               pim_result_valid_i,
  output logic [NUM_REQ-1:0] resp_valid_o,
  output logic               resp_err_o,
  output logic               timeout_err_o,
  input  logic               err_clear_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic               grant_active_q;
  logic               pim_valid_q;
  logic               resp_err_q;
  logic               timeout_err_q;

  logic [IDX_W-1:0]   winner_idx;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic               timeout_hit;

  // Scan from the farthest offset down so the requester closest to rr_ptr overwrites the rest.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    winner_idx = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid_i[j]) winner_idx = IDX_W'(j);
    end
  end

  assign rr_ptr_d    = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
  assign timeout_hit = (wait_cnt_q == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      wait_cnt_q     <= '0;
      req_ready_q    <= '0;
      resp_valid_q   <= '0;
      grant_active_q <= 1'b0;
      pim_valid_q    <= 1'b0;
      resp_err_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      pim_valid_q  <= 1'b0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      // A timeout detected below in the same cycle overrides this clear.
      if (err_clear_i) timeout_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (|req_valid_i) begin
            grant_idx_q    <= winner_idx;
            req_ready_q    <= ONE_HOT0 << winner_idx;
            pim_valid_q    <= 1'b1;
            grant_active_q <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (pim_result_valid_i) begin
            resp_valid_q <= ONE_HOT0 << grant_idx_q;
            resp_err_q   <= 1'b0;
            state_q      <= S_RESP;
          end else if (timeout_hit) begin
            resp_valid_q  <= ONE_HOT0 << grant_idx_q;
            resp_err_q    <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          resp_err_q     <= 1'b0;
          grant_active_q <= 1'b0;
          rr_ptr_q       <= rr_ptr_d;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign grant_idx_o    = grant_idx_q;
  assign grant_active_o = grant_active_q;
  assign pim_valid_o    = pim_valid_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_err_o     = resp_err_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_pim_unit_arbiter.sv
// Bench for pim_unit_arbiter: a timestamp-based job model checked every cycle, plus directed literal checks.
module tb_pim_unit_arbiter;
  localparam int N = 4;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic         man_res = 1'b0;
  logic         auto_res = 1'b0;
  logic         err_clear = 1'b0;
  logic         pim_result_valid;
  logic [N-1:0] req_ready;
  logic [1:0]   grant_idx;
  logic         grant_active;
  logic         pim_valid;
  logic [N-1:0] resp_valid;
  logic         resp_err;
  logic         timeout_err;

  assign pim_result_valid = man_res | auto_res;

  pim_unit_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .grant_idx_o        (grant_idx),
    .grant_active_o     (grant_active),
    .pim_valid_o        (pim_valid),
    .pim_result_valid_i (pim_result_valid),
    .resp_valid_o       (resp_valid),
    .resp_err_o         (resp_err),
    .timeout_err_o      (timeout_err),
    .err_clear_i        (err_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pv_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
  endtask

  // Job model: one job at a time, described by the cycle it issued and the cycle it responds.
  bit           m_busy = 0;
  int           m_issue = -10;
  int           m_resp = -10;
  int           m_idx = 0;
  int           m_ptr = 0;
  bit           m_err = 0;
  bit           m_terr = 0;
  logic [N-1:0] one = 1;

  always @(posedge clk) begin
    bit tmo;
    int w;
    cyc++;
    tmo = 0;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_idx = 0; m_terr = 0; m_err = 0;
      m_issue = -10; m_resp = -10;
    end else begin
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_busy = 1; m_idx = w; m_issue = cyc; m_resp = -1;
        end
      end else if (cyc - 1 == m_resp) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % N;
      end else if (m_resp < 0 && cyc - 1 > m_issue) begin
        if (pim_result_valid) begin
          m_resp = cyc; m_err = 0;
        end else if ((cyc - 1) - (m_issue + 1) == T - 1) begin
          m_resp = cyc; m_err = 1; tmo = 1;
        end
      end
      m_terr = tmo ? 1'b1 : (err_clear ? 1'b0 : m_terr);
    end
    #1;
    if (pim_valid) pv_count++;
    check("pim_valid",    32'(pim_valid),    32'(m_busy && cyc == m_issue));
    check("req_ready",    32'(req_ready),    (m_busy && cyc == m_issue) ? 32'(one << m_idx) : 32'd0);
    check("grant_active", 32'(grant_active), 32'(m_busy));
    check("grant_idx",    32'(grant_idx),    32'(m_idx));
    check("resp_valid",   32'(resp_valid),   (m_busy && cyc == m_resp) ? 32'(one << m_idx) : 32'd0);
    check("resp_err",     32'(resp_err),     32'(m_busy && cyc == m_resp && m_err));
    check("timeout_err",  32'(timeout_err),  32'(m_terr));
  end

  // Auto responder: raises result_valid resp_lat cycles after the pim_valid cycle (0 = off).
  int resp_lat = 0;
  int resp_cd  = 0;
  always @(negedge clk) begin
    auto_res = 1'b0;
    if (rst) resp_cd = 0;
    else if (resp_cd > 0) begin
      resp_cd = resp_cd - 1;
      if (resp_cd == 0) auto_res = 1'b1;
    end
    if (resp_lat > 0 && pim_valid) resp_cd = resp_lat;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin at = cyc; break; end
    end
    if (at < 0) bound_expired(name);
  endtask

  task automatic wait_resp(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin at = cyc; break; end
    end
    if (at < 0) bound_expired(name);
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!grant_active) begin seen = 1; break; end
    end
    if (!seen) bound_expired(name);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int t_req, t_iss, t_r, t_prev;
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    tick();
    tick();
    check("reset_outputs", 32'({req_ready, grant_idx, grant_active, pim_valid,
                                resp_valid, resp_err, timeout_err}), 32'd0);
    rst = 1'b0;

    // T1: single requester, result 3 cycles after pim_valid
    tick();
    req_valid = 4'b0001;
    t_req = cyc;
    wait_ready("t1_ready", t_iss);
    check("t1_req_latency", 32'(t_iss - t_req), 32'd1);
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_pim_valid", 32'(pim_valid), 32'h1);
    req_valid = '0;
    tick(); tick(); tick();
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
    check("t1_resp_valid", 32'(resp_valid), 32'h1);
    check("t1_resp_err", 32'(resp_err), 32'h0);
    tick();
    check("t1_idle_after", 32'(grant_active), 32'h0);
    check("t1_pim_pulses", 32'(pv_count), 32'd1);

    // T2: all requesters held, latency 2: grants 0,1,2,3,0 every 5 cycles
    reset_dut();
    resp_lat = 2;
    req_valid = 4'b1111;
    t_prev = -1;
    for (int j = 0; j < 5; j++) begin
      wait_ready("t2_ready", t_iss);
      check("t2_grant_order", 32'(grant_idx), 32'(order[j]));
      if (j > 0) check("t2_job_period", 32'(t_iss - t_prev), 32'd5);
      t_prev = t_iss;
    end
    req_valid = '0;
    wait_idle("t2_idle");
    resp_lat = 0;

    // T3: job on requester 1 moves rr_ptr to 2, then 0101 grants 2 before 0
    tick();
    resp_lat = 2;
    req_valid = 4'b0010;
    wait_ready("t3_first", t_iss);
    check("t3_first_idx", 32'(grant_idx), 32'd1);
    req_valid = '0;
    wait_idle("t3_idle1");
    req_valid = 4'b0101;
    wait_ready("t3_second", t_iss);
    check("t3_second_idx", 32'(grant_idx), 32'd2);
    check("t3_second_ready", 32'(req_ready), 32'h4);
    req_valid = 4'b0001;
    wait_ready("t3_third", t_iss);
    check("t3_third_idx", 32'(grant_idx), 32'd0);
    req_valid = '0;
    wait_idle("t3_idle2");
    resp_lat = 0;

    // T4: watchdog timeout, sticky error, clear, clear coincident with a new timeout
    tick();
    req_valid = 4'b0100;
    wait_ready("t4_ready", t_iss);
    req_valid = '0;
    wait_resp("t4_resp", t_r);
    check("t4_timeout_latency", 32'(t_r - t_iss), 32'(T + 1));
    check("t4_resp_valid", 32'(resp_valid), 32'h4);
    check("t4_resp_err", 32'(resp_err), 32'h1);
    check("t4_timeout_err", 32'(timeout_err), 32'h1);
    tick(); tick(); tick();
    check("t4_sticky", 32'(timeout_err), 32'h1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t4_cleared", 32'(timeout_err), 32'h0);
    req_valid = 4'b1000;
    wait_ready("t4_ready2", t_iss);
    check("t4_second_idx", 32'(grant_idx), 32'd3);
    req_valid = '0;
    repeat (T) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t4_second_resp_err", 32'(resp_err), 32'h1);
    check("t4_second_resp_valid", 32'(resp_valid), 32'h8);
    check("t4_clear_vs_timeout", 32'(timeout_err), 32'h1);
    wait_idle("t4_idle");

    // T5: asynchronous reset mid-WAIT, late result afterwards is ignored
    tick();
    req_valid = 4'b0001;
    wait_ready("t5_ready", t_iss);
    req_valid = '0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t5_async_reset", 32'({req_ready, grant_idx, grant_active, pim_valid,
                                 resp_valid, resp_err, timeout_err}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
    tick();
    tick();
    check("t5_no_late_resp", 32'(resp_valid), 32'h0);
    check("t5_idle", 32'(grant_active), 32'h0);

    // T6: result pulses in IDLE and ISSUE are ignored; result on the timeout edge wins
    tick();
    req_valid = 4'b0010;
    man_res = 1'b1;
    tick();
    check("t6_pim_valid", 32'(pim_valid), 32'h1);
    check("t6_grant_idx", 32'(grant_idx), 32'd1);
    req_valid = '0;
    tick();
    man_res = 1'b0;
    tick();
    check("t6_no_early_resp", 32'(resp_valid), 32'h0);
    check("t6_still_waiting", 32'(grant_active), 32'h1);
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
    check("t6_resp_valid", 32'(resp_valid), 32'h2);
    check("t6_resp_err", 32'(resp_err), 32'h0);
    wait_idle("t6_idle1");
    req_valid = 4'b0100;
    wait_ready("t6_ready2", t_iss);
    req_valid = '0;
    repeat (T) tick();
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
    check("t6_edge_resp_valid", 32'(resp_valid), 32'h4);
    check("t6_edge_resp_err", 32'(resp_err), 32'h0);
    check("t6_edge_timeout_err", 32'(timeout_err), 32'h0);
    wait_idle("t6_idle2");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
